// File: rtl/ram_arbiter_2p_if.sv
// ram_arbiter_2p_if
// Bundles the two client request/response channels and the RAM port of the
// two-client RAM arbiter.
//   Client X (X = 0/1):
//     reqX, weX, addrX, wdataX  -> request: held stable until ackX
//     ackX                      <- one-cycle pulse, command issued to the RAM
//     rdataX, rvalidX           <- registered read data and its one-cycle strobe
//   RAM port:
//     ram_wr, ram_waddr, ram_din   <- write strobe, address, data
//     ram_rd, ram_raddr            <- read strobe, address
//     ram_dout                     -> read data, valid RD_LAT cycles after ram_rd
// Modports: slave = arbiter side, master = clients + RAM side.
interface ram_arbiter_2p_if #(
   parameter int AW = 6,
   parameter int DW = 16
);
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          ack0;
   logic          ack1;
   logic [DW-1:0] rdata0;
   logic [DW-1:0] rdata1;
   logic          rvalid0;
   logic          rvalid1;
   logic          ram_wr;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_din;
   logic          ram_rd;
   logic [AW-1:0] ram_raddr;
   logic [DW-1:0] ram_dout;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
      output ack0, ack1, rdata0, rdata1, rvalid0, rvalid1,
             ram_wr, ram_waddr, ram_din, ram_rd, ram_raddr
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
      input  ack0, ack1, rdata0, rdata1, rvalid0, rvalid1,
             ram_wr, ram_waddr, ram_din, ram_rd, ram_raddr
   );
endinterface

// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p
// Round-robin arbiter and sequencer placing single-word read/write requests
// from two clients onto one RAM port (separate write and read address/data
// paths, shared command slot). One transaction is outstanding at a time:
// IDLE picks a winner, CMD issues the strobe and acks, RWAIT counts the RAM
// read latency, RDONE pulses rvalid to the owner.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active low
//   bus  - ram_arbiter_2p_if.slave: client channels and RAM port
// Parameters: AW address width, DW data width, RD_LAT RAM read latency (1..4).
module ram_arbiter_2p #(
   parameter int AW     = 6,
   parameter int DW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   ram_arbiter_2p_if.slave bus
);

   localparam int CW = 3;

   typedef enum logic [1:0] {IDLE, CMD, RWAIT, RDONE} state_t;

   state_t        state;
   state_t        state_nxt;

   logic          ptr;
   logic          owner;
   logic          is_rd;
   logic [CW-1:0] cnt;
   logic [AW-1:0] waddr;
   logic [AW-1:0] raddr;
   logic [DW-1:0] din;
   logic [DW-1:0] rdata0;
   logic [DW-1:0] rdata1;

   logic          grant;
   logic          grant_sel;
   logic          capture;
   logic          ack0;
   logic          ack1;
   logic          rvalid0;
   logic          rvalid1;
   logic          ram_wr;
   logic          ram_rd;

   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Command of whichever client the IDLE decision selects
   assign sel_we    = grant_sel ? bus.we1    : bus.we0;
   assign sel_addr  = grant_sel ? bus.addr1  : bus.addr0;
   assign sel_wdata = grant_sel ? bus.wdata1 : bus.wdata0;

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_sel = ptr;
      capture   = 1'b0;
      ack0      = 1'b0;
      ack1      = 1'b0;
      rvalid0   = 1'b0;
      rvalid1   = 1'b0;
      ram_wr    = 1'b0;
      ram_rd    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               grant = 1'b1;
               // A lone requester wins outright; on a tie the pointer decides
               grant_sel = (bus.req0 && bus.req1) ? ptr : bus.req1;
               state_nxt = CMD;
            end
         end
         CMD: begin
            ack0      = ~owner;
            ack1      = owner;
            ram_wr    = ~is_rd;
            ram_rd    = is_rd;
            state_nxt = is_rd ? RWAIT : IDLE;
         end
         RWAIT: begin
            // Counter is about to reach zero: RAM data is valid this cycle
            if (cnt == 3'd1) begin
               capture   = 1'b1;
               state_nxt = RDONE;
            end
         end
         RDONE: begin
            rvalid0   = ~owner;
            rvalid1   = owner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Reset clears everything, so a read in flight is simply abandoned
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr    <= 1'b0;
         owner  <= 1'b0;
         is_rd  <= 1'b0;
         cnt    <= '0;
         waddr  <= '0;
         raddr  <= '0;
         din    <= '0;
         rdata0 <= '0;
         rdata1 <= '0;
      end else begin
         if (grant) begin
            ptr   <= ~grant_sel;
            owner <= grant_sel;
            is_rd <= ~sel_we;
            if (sel_we) begin
               waddr <= sel_addr;
               din   <= sel_wdata;
            end else begin
               raddr <= sel_addr;
            end
         end
         if (state == CMD && is_rd) begin
            cnt <= CW'(RD_LAT);
         end else if (state == RWAIT) begin
            cnt <= cnt - 3'd1;
         end
         if (capture) begin
            if (owner) begin
               rdata1 <= bus.ram_dout;
            end else begin
               rdata0 <= bus.ram_dout;
            end
         end
      end
   end

   assign bus.ack0      = ack0;
   assign bus.ack1      = ack1;
   assign bus.rvalid0   = rvalid0;
   assign bus.rvalid1   = rvalid1;
   assign bus.rdata0    = rdata0;
   assign bus.rdata1    = rdata1;
   assign bus.ram_wr    = ram_wr;
   assign bus.ram_rd    = ram_rd;
   assign bus.ram_waddr = waddr;
   assign bus.ram_raddr = raddr;
   assign bus.ram_din   = din;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// tb_ram_arbiter_2p
// Directed bench for ram_arbiter_2p. Three arbiters with RAM read latencies
// 1, 4 and 2 each drive their own behavioural RAM (write on ram_wr, read
// pipeline of RD_LAT stages behind ram_rd). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_ram_arbiter_2p;

   logic clk = 1'b0;
   logic rst1;
   logic rst4;
   logic rst2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ram_arbiter_2p_if #(.AW(6), .DW(16)) b1 ();
   ram_arbiter_2p_if #(.AW(6), .DW(16)) b4 ();
   ram_arbiter_2p_if #(.AW(6), .DW(16)) b2 ();

   ram_arbiter_2p #(.AW(6), .DW(16), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst1), .bus(b1.slave));
   ram_arbiter_2p #(.AW(6), .DW(16), .RD_LAT(4)) dut4 (.clk(clk), .rst(rst4), .bus(b4.slave));
   ram_arbiter_2p #(.AW(6), .DW(16), .RD_LAT(2)) dut2 (.clk(clk), .rst(rst2), .bus(b2.slave));

   // Behavioural RAMs
   logic [15:0] mem1 [64];
   logic [15:0] mem4 [64];
   logic [15:0] mem2 [64];
   logic [15:0] p1 [4];
   logic [15:0] p4 [4];
   logic [15:0] p2 [4];

   always @(posedge clk) begin
      if (b1.ram_wr) mem1[b1.ram_waddr] <= b1.ram_din;
      if (b1.ram_rd) p1[0] <= mem1[b1.ram_raddr];
      for (int i = 1; i < 4; i++) p1[i] <= p1[i-1];
   end
   always @(posedge clk) begin
      if (b4.ram_wr) mem4[b4.ram_waddr] <= b4.ram_din;
      if (b4.ram_rd) p4[0] <= mem4[b4.ram_raddr];
      for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
   end
   always @(posedge clk) begin
      if (b2.ram_wr) mem2[b2.ram_waddr] <= b2.ram_din;
      if (b2.ram_rd) p2[0] <= mem2[b2.ram_raddr];
      for (int i = 1; i < 4; i++) p2[i] <= p2[i-1];
   end

   assign b1.ram_dout = p1[0];
   assign b4.ram_dout = p4[3];
   assign b2.ram_dout = p2[1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req1(input bit c, input bit on, input bit we,
                           input logic [5:0] a, input logic [15:0] d);
      if (!c) begin
         b1.req0 = on; b1.we0 = we; b1.addr0 = a; b1.wdata0 = d;
      end else begin
         b1.req1 = on; b1.we1 = we; b1.addr1 = a; b1.wdata1 = d;
      end
   endtask

   // Single write by client c on the RD_LAT=1 arbiter
   task automatic cl_write(input bit c, input logic [5:0] a, input logic [15:0] d);
      set_req1(c, 1'b1, 1'b1, a, d);
      tick();
      chk("wr_ack", 32'({b1.ack1, b1.ack0}), c ? 32'h2 : 32'h1);
      chk("wr_strobe", 32'({b1.ram_wr, b1.ram_rd}), 32'h2);
      chk("wr_addr", 32'(b1.ram_waddr), 32'(a));
      chk("wr_data", 32'(b1.ram_din), 32'(d));
      set_req1(c, 1'b0, 1'b0, 6'd0, 16'd0);
      tick();
      chk("wr_idle", 32'({b1.ack1, b1.ack0, b1.ram_wr, b1.ram_rd}), 32'h0);
   endtask

   // Single read by client c on the RD_LAT=1 arbiter
   task automatic cl_read(input bit c, input logic [5:0] a, input logic [15:0] exp);
      set_req1(c, 1'b1, 1'b0, a, 16'd0);
      tick();
      chk("rd_ack", 32'({b1.ack1, b1.ack0}), c ? 32'h2 : 32'h1);
      chk("rd_strobe", 32'({b1.ram_wr, b1.ram_rd}), 32'h1);
      chk("rd_addr", 32'(b1.ram_raddr), 32'(a));
      set_req1(c, 1'b0, 1'b0, 6'd0, 16'd0);
      tick();
      chk("rd_wait", 32'({b1.rvalid1, b1.rvalid0, b1.ram_rd}), 32'h0);
      tick();
      chk("rd_rvalid", 32'({b1.rvalid1, b1.rvalid0}), c ? 32'h2 : 32'h1);
      chk("rd_data", 32'(c ? b1.rdata1 : b1.rdata0), 32'(exp));
      tick();
      chk("rd_rvalid_end", 32'({b1.rvalid1, b1.rvalid0}), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst1 = 1'b0; rst4 = 1'b0; rst2 = 1'b0;
      {b4.req0, b4.req1, b4.we0, b4.we1} = 4'b0;
      b4.addr0 = '0; b4.addr1 = '0; b4.wdata0 = '0; b4.wdata1 = '0;
      {b2.req0, b2.req1, b2.we0, b2.we1} = 4'b0;
      b2.addr0 = '0; b2.addr1 = '0; b2.wdata0 = '0; b2.wdata1 = '0;

      // Reset with random client activity
      for (int i = 0; i < 2; i++) begin
         {b1.req0, b1.req1, b1.we0, b1.we1} = 4'($urandom);
         b1.addr0  = 6'($urandom);
         b1.addr1  = 6'($urandom);
         b1.wdata0 = 16'($urandom);
         b1.wdata1 = 16'($urandom);
         tick();
      end
      chk("rst_strobes", 32'({b1.ack0, b1.ack1, b1.rvalid0, b1.rvalid1, b1.ram_wr, b1.ram_rd}), 32'h0);
      chk("rst_waddr", 32'(b1.ram_waddr), 32'h0);
      chk("rst_raddr", 32'(b1.ram_raddr), 32'h0);
      chk("rst_din", 32'(b1.ram_din), 32'h0);
      chk("rst_rdata", 32'({b1.rdata0, b1.rdata1}), 32'h0);
      set_req1(1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
      set_req1(1'b1, 1'b0, 1'b0, 6'd0, 16'd0);
      rst1 = 1'b1; rst4 = 1'b1; rst2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_quiet", 32'({b1.ram_wr, b1.ram_rd, b1.ack0, b1.ack1}), 32'h0);
      end

      // Client0 write then read back, RD_LAT=1
      cl_write(1'b0, 6'd1, 16'hadca);
      cl_read(1'b0, 6'd1, 16'hadca);

      // Reset pulse: pointer back to 0, rdata cleared
      rst1 = 1'b0;
      tick();
      rst1 = 1'b1;
      chk("rst2_rdata0", 32'(b1.rdata0), 32'h0);
      chk("rst2_strobes", 32'({b1.ack0, b1.ack1, b1.rvalid0, b1.rvalid1, b1.ram_wr, b1.ram_rd}), 32'h0);

      // Simultaneous writes: client0 first, client1 two cycles later
      set_req1(1'b0, 1'b1, 1'b1, 6'd6, 16'h5767);
      set_req1(1'b1, 1'b1, 1'b1, 6'd51, 16'ha7cd);
      tick();
      chk("sim_ack_first", 32'({b1.ack1, b1.ack0}), 32'h1);
      chk("sim_waddr0", 32'(b1.ram_waddr), 32'd6);
      chk("sim_din0", 32'(b1.ram_din), 32'h5767);
      set_req1(1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
      tick();
      chk("sim_gap", 32'({b1.ack1, b1.ack0, b1.ram_wr}), 32'h0);
      tick();
      chk("sim_ack_second", 32'({b1.ack1, b1.ack0}), 32'h2);
      chk("sim_waddr1", 32'(b1.ram_waddr), 32'd51);
      chk("sim_din1", 32'(b1.ram_din), 32'ha7cd);
      set_req1(1'b1, 1'b0, 1'b0, 6'd0, 16'd0);
      tick();
      cl_read(1'b0, 6'd6, 16'h5767);
      cl_read(1'b1, 6'd51, 16'ha7cd);

      // Both clients hold read requests: grants alternate 0,1,0,1
      set_req1(1'b0, 1'b1, 1'b0, 6'd6, 16'd0);
      set_req1(1'b1, 1'b1, 1'b0, 6'd51, 16'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_ack", 32'({b1.ack1, b1.ack0}), (k % 2) ? 32'h2 : 32'h1);
         chk("rr_raddr", 32'(b1.ram_raddr), (k % 2) ? 32'd51 : 32'd6);
         tick();
         chk("rr_wait", 32'({b1.rvalid1, b1.rvalid0}), 32'h0);
         tick();
         chk("rr_rvalid", 32'({b1.rvalid1, b1.rvalid0}), (k % 2) ? 32'h2 : 32'h1);
         chk("rr_rdata", 32'((k % 2) ? b1.rdata1 : b1.rdata0), (k % 2) ? 32'ha7cd : 32'h5767);
         tick();
         if (k == 3) begin
            set_req1(1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
            set_req1(1'b1, 1'b0, 1'b0, 6'd0, 16'd0);
         end
         chk("rr_idle", 32'({b1.ack1, b1.ack0, b1.rvalid1, b1.rvalid0}), 32'h0);
      end
      tick();
      chk("rr_done", 32'({b1.ack1, b1.ack0, b1.ram_rd}), 32'h0);

      // RD_LAT=4: reset while waiting on a client0 read
      b4.req0 = 1'b1; b4.we0 = 1'b0; b4.addr0 = 6'd9;
      tick();
      chk("l4_ack", 32'({b4.ack1, b4.ack0, b4.ram_rd}), 32'h3);
      b4.req0 = 1'b0;
      tick();
      tick();
      rst4 = 1'b0;
      tick();
      rst4 = 1'b1;
      chk("l4_rst", 32'({b4.rvalid1, b4.rvalid0, b4.ram_wr, b4.ram_rd, b4.ack1, b4.ack0}), 32'h0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("l4_quiet", 32'({b4.rvalid1, b4.rvalid0, b4.ram_wr, b4.ram_rd, b4.ack1, b4.ack0}), 32'h0);
      end
      b4.req0 = 1'b1; b4.we0 = 1'b1; b4.addr0 = 6'd2; b4.wdata0 = 16'h1111;
      b4.req1 = 1'b1; b4.we1 = 1'b1; b4.addr1 = 6'd3; b4.wdata1 = 16'h2222;
      tick();
      chk("l4_ptr0", 32'({b4.ack1, b4.ack0, b4.ram_wr}), 32'h3);
      chk("l4_waddr0", 32'(b4.ram_waddr), 32'd2);
      b4.req0 = 1'b0;
      tick();
      tick();
      chk("l4_ack1", 32'({b4.ack1, b4.ack0, b4.ram_wr}), 32'h5);
      chk("l4_din1", 32'(b4.ram_din), 32'h2222);
      b4.req1 = 1'b0;
      tick();
      b4.req1 = 1'b1; b4.we1 = 1'b0; b4.addr1 = 6'd3;
      tick();
      chk("l4_rd_ack", 32'({b4.ack1, b4.ack0, b4.ram_rd}), 32'h5);
      b4.req1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("l4_wait", 32'({b4.rvalid1, b4.rvalid0}), 32'h0);
      end
      tick();
      chk("l4_rvalid", 32'({b4.rvalid1, b4.rvalid0}), 32'h2);
      chk("l4_rdata", 32'(b4.rdata1), 32'h2222);
      tick();
      chk("l4_end", 32'({b4.rvalid1, b4.rvalid0}), 32'h0);

      // RD_LAT=2: write then read, rvalid four cycles after request sample
      b2.req0 = 1'b1; b2.we0 = 1'b1; b2.addr0 = 6'd31; b2.wdata0 = 16'ha23d;
      tick();
      chk("l2_wr", 32'({b2.ack0, b2.ram_wr}), 32'h3);
      b2.req0 = 1'b0;
      tick();
      b2.req0 = 1'b1; b2.we0 = 1'b0; b2.addr0 = 6'd31;
      tick();
      chk("l2_rd_ack", 32'({b2.ack0, b2.ram_rd}), 32'h3);
      b2.req0 = 1'b0;
      tick();
      chk("l2_wait1", 32'({b2.rvalid1, b2.rvalid0}), 32'h0);
      tick();
      chk("l2_wait2", 32'({b2.rvalid1, b2.rvalid0}), 32'h0);
      tick();
      chk("l2_rvalid", 32'({b2.rvalid1, b2.rvalid0}), 32'h1);
      chk("l2_rdata", 32'(b2.rdata0), 32'ha23d);
      tick();
      chk("l2_end", 32'({b2.rvalid1, b2.rvalid0}), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
